// File: rtl/lfsr_step_if.sv
// lfsr_step_if: seed handshake and LFSR datapath bundle between host/datapath (master) and step controller (slave)
interface lfsr_step_if #(parameter int WIDTH = 16);
    logic             seed_valid;
    logic             seed_ready;
    logic [WIDTH-1:0] seed_data;
    logic [WIDTH-1:0] lfsr_q;
    logic             shift_en;
    logic             load_en;
    logic [WIDTH-1:0] load_data;
    modport master (output seed_valid, seed_data, lfsr_q, input seed_ready, shift_en, load_en, load_data);
    modport slave  (input seed_valid, seed_data, lfsr_q, output seed_ready, shift_en, load_en, load_data);
endinterface

// File: rtl/lfsr_step_ctrl.sv
// lfsr_step_ctrl: sequences seed loads and timed, counted or free-running shifts of an external LFSR
//   clk, rst_n          : clock, asynchronous active-low reset
//   start, stop         : begin a run (sampled in IDLE), abort a run (sampled in RUN)
//   step_count, div_max : shifts per run (0 = free-run), tick period minus 1; both captured at start
//   bus                 : seed handshake, LFSR state in, shift/load strobes and load value out
//   busy, done, lockup  : run/load activity, completion pulse, sticky all-zero-state flag
module lfsr_step_ctrl #(
    parameter int WIDTH    = 16,
    parameter int CNT_BITS = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                stop,
    input  logic [CNT_BITS-1:0] step_count,
    input  logic [31:0]         div_max,
    lfsr_step_if.slave          bus,
    output logic                busy,
    output logic                done,
    output logic                lockup
);
    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;
    state_t              state;
    logic [CNT_BITS-1:0] remaining;
    logic [31:0]         div_q;
    logic [31:0]         tick;
    logic                free;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            bus.shift_en   <= 1'b0;
            bus.load_en    <= 1'b0;
            bus.load_data  <= '0;
            bus.seed_ready <= 1'b1;
            remaining      <= '0;
            div_q          <= '0;
            tick           <= '0;
            free           <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            lockup         <= 1'b0;
        end else begin
            bus.shift_en <= 1'b0;
            bus.load_en  <= 1'b0;
            done         <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.seed_valid) begin
                        state          <= LOAD;
                        bus.load_en    <= 1'b1;
                        // an all-zero seed would lock the LFSR, so substitute 1
                        bus.load_data  <= (bus.seed_data == '0) ? WIDTH'(1) : bus.seed_data;
                        busy           <= 1'b1;
                        bus.seed_ready <= 1'b0;
                    end else if (start) begin
                        state          <= RUN;
                        remaining      <= step_count;
                        div_q          <= div_max;
                        tick           <= '0;
                        free           <= (step_count == '0);
                        lockup         <= 1'b0;
                        busy           <= 1'b1;
                        bus.seed_ready <= 1'b0;
                    end
                end
                LOAD: begin
                    state          <= IDLE;
                    busy           <= 1'b0;
                    bus.seed_ready <= 1'b1;
                end
                RUN: begin
                    // priority: lockup recovery, then abort, then completion, then tick
                    if (bus.lfsr_q == '0) begin
                        state         <= LOAD;
                        lockup        <= 1'b1;
                        bus.load_en   <= 1'b1;
                        bus.load_data <= WIDTH'(1);
                    end else if (stop) begin
                        state          <= IDLE;
                        busy           <= 1'b0;
                        bus.seed_ready <= 1'b1;
                    end else if (!free && remaining == '0) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end else if (tick == div_q) begin
                        tick         <= '0;
                        bus.shift_en <= 1'b1;
                        if (!free) remaining <= remaining - CNT_BITS'(1);
                    end else begin
                        tick <= tick + 32'd1;
                    end
                end
                DONE: begin
                    state          <= IDLE;
                    busy           <= 1'b0;
                    bus.seed_ready <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/lfsr_step_ctrl.md
LFSR_STEP_CTRL -- requirements
Module: lfsr_step_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 16: width of the controlled LFSR register.
REQ-002 SHALL have parameter CNT_BITS, default 16: width of the step counter.
REQ-003 SHALL have port clk  input  1: single clock; all state updates on posedge clk.
REQ-004 SHALL have port rst_n  input  1: reset, asynchronous and active-low.
REQ-005 SHALL have port start  input  1: level, sampled in IDLE only; begins a run.
REQ-006 SHALL have port stop  input  1: level, sampled in RUN only; aborts a run.
REQ-007 SHALL have port step_count  input  CNT_BITS: shifts per run, captured at start; 0 means free-run.
REQ-008 SHALL have port div_max  input  32: tick period minus 1, captured at start.
REQ-009 SHALL have port seed_valid  input  1: seed offered.
REQ-010 SHALL have port seed_data  input  WIDTH: seed value.
REQ-011 SHALL have port seed_ready  output  1: seed accepted when seed_valid and seed_ready are both 1 on a posedge.
REQ-012 SHALL have port lfsr_q  input  WIDTH: current LFSR state from the datapath.
REQ-013 SHALL have port shift_en  output  1: one-cycle strobe; LFSR advances one step.
REQ-014 SHALL have port load_en  output  1: one-cycle strobe; LFSR loads load_data.
REQ-015 SHALL have port load_data  output  WIDTH: value to load.
REQ-016 SHALL have port busy  output  1: high in LOAD and RUN.
REQ-017 SHALL have port done  output  1: one-cycle pulse on normal run completion.
REQ-018 SHALL have port lockup  output  1: sticky flag, all-zero LFSR state detected in RUN.

Function
REQ-019 SHALL implement states IDLE, LOAD, RUN, DONE; all outputs registered.
REQ-020 seed_ready SHALL be 1 only in IDLE.
REQ-021 IDLE: seed handshake -> LOAD, latching seed_data; otherwise start -> RUN; seed handshake wins over simultaneous start, and start is then ignored.
REQ-022 LOAD: load_en=1 for exactly one cycle with load_data = latched seed, or 1 if latched seed is all-zero; then -> IDLE.
REQ-023 On IDLE->RUN, SHALL latch step_count into remaining, latch div_max, clear tick counter, clear lockup.
REQ-024 RUN: tick counter increments each cycle; when equal to latched div_max it asserts shift_en for one cycle and wraps to 0.
REQ-025 First shift_en SHALL occur div_max+1 cycles after the start-sampling edge; subsequent shifts every div_max+1 cycles; div_max=0 gives shift_en every cycle.
REQ-026 Each shift in counted mode SHALL decrement remaining; the shift taking remaining from 1 to 0 -> DONE; exactly step_count shifts per run.
REQ-027 Free-run (step_count=0) SHALL shift indefinitely until stop or lockup; remaining does not wrap.
REQ-028 DONE: done=1 for one cycle, then -> IDLE.
REQ-029 stop in RUN SHALL -> IDLE next edge, with no shift_en and no done that cycle; stop overrides a coincident tick.
REQ-030 lfsr_q all-zero in RUN SHALL set lockup, suppress shift_en that cycle, and -> LOAD with load_data=1; no done pulse; lockup is checked before stop.
REQ-031 lockup SHALL remain 1 until the next IDLE->RUN transition or reset.
REQ-032 shift_en and load_en SHALL never be 1 in the same cycle.

Reset
REQ-033 rst_n=0 SHALL immediately force IDLE; shift_en, load_en, done, lockup, busy = 0; load_data, remaining, tick counter = 0; seed_ready = 1 after release.
REQ-034 Reset asserted mid-RUN or mid-LOAD SHALL abort without any further strobe.

Verification
REQ-035 seed_valid=1, seed_data=16'hACE1 in IDLE -> seed_ready=1; next cycle load_en=1, load_data=16'hACE1, busy=1; then IDLE.
REQ-036 seed_data=0 handshake -> load_en=1 with load_data=16'h0001.
REQ-037 start with step_count=3, div_max=4, lfsr_q nonzero -> shift_en at cycles 5, 10, 15 after start edge; done pulse at 16; busy 0 at 17.
REQ-038 start with step_count=0, div_max=0 -> shift_en every cycle; stop at cycle 7 -> no shift_en at 7, IDLE at 8, no done.
REQ-039 RUN with lfsr_q forced to 0 -> lockup=1, no shift_en, next cycle load_en=1 with load_data=1; lockup stays 1 until next start.
REQ-040 rst_n pulsed low mid-RUN between ticks -> all outputs 0 asynchronously; no shift_en after release until a new start.
